// File: rtl/gp_pkg.sv
// Shared encodings, record types and address helper for the GraphPulse edge fetch path.
package gp_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } bus_command_t;

   localparam logic [1:0] DOUBLE = 2'h3;

   typedef struct packed {
      logic [15:0] dst;
      logic [31:0] weight;
   } edge_rec_t;

   typedef enum logic [2:0] {
      StIdle,
      StPtrReq,
      StPtrWait,
      StEdge,
      StDrain
   } fetch_state_t;

   // Byte address of 64-bit word 'index' in a table at 'base', modulo 2^XLEN.
   function automatic logic [XLEN-1:0] dword_addr(input logic [XLEN-1:0] base,
                                                  input logic [31:0]     index);
      return base + (index << 3);
   endfunction

endpackage

// File: rtl/edge_rob.sv
// In-order reorder buffer for tagged edge loads: allocate at tail, fill by tag match,
// retire from head once filled.
module edge_rob
   import gp_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          alloc,
   input  logic [3:0]    alloc_tag,
   input  logic [3:0]    fill_tag,
   input  logic [47:0]   fill_data,
   input  logic          pop,
   output logic          head_filled,
   output logic [47:0]   head_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] filled_q;
   logic [3:0]       tag_q  [DEPTH];
   edge_rec_t        data_q [DEPTH];
   logic [PW-1:0]    head_q;
   logic [PW-1:0]    tail_q;
   logic [CW-1:0]    count_q;
   logic             do_alloc;
   logic             do_pop;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign count       = count_q;
   assign full        = (count_q == CW'(DEPTH));
   assign empty       = (count_q == '0);
   assign head_filled = valid_q[head_q] & filled_q[head_q];
   assign head_data   = data_q[head_q];
   assign do_alloc    = alloc & ~full;
   assign do_pop      = pop & head_filled;

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q  <= '0;
         filled_q <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
      end else begin
         // Only pending slots may match, so stale or unknown tags fall through.
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[PW'(i)] && !filled_q[PW'(i)] && fill_tag != 4'd0 &&
                tag_q[i] == fill_tag) begin
               filled_q[PW'(i)] <= 1'b1;
               data_q[i]        <= fill_data;
            end
         end
         if (do_pop) begin
            valid_q[head_q]  <= 1'b0;
            filled_q[head_q] <= 1'b0;
            head_q           <= wrap_inc(head_q);
         end
         if (do_alloc) begin
            valid_q[tail_q]  <= 1'b1;
            filled_q[tail_q] <= 1'b0;
            tag_q[tail_q]    <= alloc_tag;
            tail_q           <= wrap_inc(tail_q);
         end
         count_q <= count_q + CW'(do_alloc) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/edge_fetch_unit.sv
// Fetches a vertex's row-pointer word, then streams its edges through a tagged load
// reorder buffer to the propagation stage in issue order.
module edge_fetch_unit
   import gp_pkg::*;
#(
   parameter int unsigned     MAX_OUTSTANDING = 4,
   parameter logic [XLEN-1:0] ROWPTR_BASE     = 32'h0000_0000,
   parameter logic [XLEN-1:0] EDGE_BASE       = 32'h0001_0000
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            ev_valid,
   input  logic [15:0]     ev_vid,
   input  logic [31:0]     ev_delta,
   output logic            ev_ready,
   output logic            edge_valid,
   output logic [15:0]     edge_dst,
   output logic [31:0]     edge_weight,
   output logic [31:0]     edge_delta,
   output logic            edge_last,
   input  logic            edge_ready,
   output logic [1:0]      edgemem_command,
   output logic [XLEN-1:0] edgemem_addr,
   output logic [63:0]     edgemem_st_data,
   output logic [1:0]      edgemem_size,
   input  logic [3:0]      edgemem_response,
   input  logic [63:0]     edgemem_ld_data,
   input  logic [3:0]      edgemem_tag
);

   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

   fetch_state_t    state_q;
   bus_command_t    cmd_q;
   logic [XLEN-1:0] addr_q;
   logic [31:0]     delta_q;
   logic [31:0]     edge_count_q;
   logic [31:0]     edge_ptr_q;
   logic [31:0]     issue_idx_q;
   logic [31:0]     emit_cnt_q;
   logic [3:0]      ptr_tag_q;

   logic            mem_accept;
   logic            issue_fire;
   logic            pop;
   logic            ptr_hit;
   logic [31:0]     issue_next;
   logic [CW-1:0]   occ_next;

   logic            rob_head_filled;
   logic [47:0]     rob_head_data;
   logic            rob_full;
   logic            rob_empty;
   logic [CW-1:0]   rob_count;
   edge_rec_t       head_rec;

   edge_rob #(
      .DEPTH(MAX_OUTSTANDING)
   ) u_rob (
      .clock      (clock),
      .reset      (reset),
      .alloc      (issue_fire),
      .alloc_tag  (edgemem_response),
      .fill_tag   (edgemem_tag),
      .fill_data  ({edgemem_ld_data[63:48], edgemem_ld_data[31:0]}),
      .pop        (pop),
      .head_filled(rob_head_filled),
      .head_data  (rob_head_data),
      .full       (rob_full),
      .empty      (rob_empty),
      .count      (rob_count)
   );

   assign head_rec        = rob_head_data;
   assign ev_ready        = (state_q == StIdle);
   assign edge_valid      = rob_head_filled;
   assign edge_dst        = head_rec.dst;
   assign edge_weight     = head_rec.weight;
   assign edge_delta      = delta_q;
   assign edge_last       = edge_valid && (emit_cnt_q == edge_count_q - 32'd1);
   assign edgemem_command = cmd_q;
   assign edgemem_addr    = addr_q;
   assign edgemem_st_data = '0;
   assign edgemem_size    = DOUBLE;

   assign mem_accept = (cmd_q == BUS_LOAD) && (edgemem_response != 4'd0);
   assign issue_fire = mem_accept && (state_q == StEdge) && !rob_full;
   assign pop        = edge_valid && edge_ready;
   assign ptr_hit    = (edgemem_tag != 4'd0) && (edgemem_tag == ptr_tag_q);
   assign issue_next = issue_idx_q + 32'(issue_fire);
   // Occupancy as seen next cycle, so the registered request never targets a full buffer.
   assign occ_next   = rob_count + CW'(issue_fire) - CW'(pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         cmd_q        <= BUS_NONE;
         addr_q       <= '0;
         delta_q      <= '0;
         edge_count_q <= '0;
         edge_ptr_q   <= '0;
         issue_idx_q  <= '0;
         emit_cnt_q   <= '0;
         ptr_tag_q    <= '0;
      end else begin
         if (pop) begin
            emit_cnt_q <= emit_cnt_q + 32'd1;
         end
         unique case (state_q)
            StIdle: begin
               if (ev_valid) begin
                  delta_q <= ev_delta;
                  cmd_q   <= BUS_LOAD;
                  addr_q  <= dword_addr(ROWPTR_BASE, {16'h0000, ev_vid});
                  state_q <= StPtrReq;
               end
            end
            StPtrReq: begin
               if (mem_accept) begin
                  ptr_tag_q <= edgemem_response;
                  cmd_q     <= BUS_NONE;
                  state_q   <= StPtrWait;
               end
            end
            StPtrWait: begin
               if (ptr_hit) begin
                  edge_count_q <= edgemem_ld_data[63:32];
                  edge_ptr_q   <= edgemem_ld_data[31:0];
                  issue_idx_q  <= '0;
                  emit_cnt_q   <= '0;
                  if (edgemem_ld_data[63:32] == 32'd0) begin
                     state_q <= StIdle;
                  end else begin
                     cmd_q   <= BUS_LOAD;
                     addr_q  <= dword_addr(EDGE_BASE, edgemem_ld_data[31:0]);
                     state_q <= StEdge;
                  end
               end
            end
            StEdge: begin
               issue_idx_q <= issue_next;
               if (issue_next == edge_count_q) begin
                  cmd_q   <= BUS_NONE;
                  state_q <= StDrain;
               end else if (occ_next < CW'(MAX_OUTSTANDING)) begin
                  cmd_q  <= BUS_LOAD;
                  addr_q <= dword_addr(EDGE_BASE, edge_ptr_q + issue_next);
               end else begin
                  cmd_q <= BUS_NONE;
               end
            end
            StDrain: begin
               if (rob_empty) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_edge_fetch_unit.sv
// Scoreboarded bench: a tagged memory model with random latency/acceptance feeds the DUT,
// expected edges are derived from the row/edge tables when each event is sent.
module tb_edge_fetch_unit;
   import gp_pkg::*;

   localparam logic [31:0] ROW = 32'h0000_0000;
   localparam logic [31:0] EB  = 32'h0001_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        ev_valid;
   logic [15:0] ev_vid;
   logic [31:0] ev_delta;
   logic        ev_ready;
   logic        edge_valid;
   logic [15:0] edge_dst;
   logic [31:0] edge_weight;
   logic [31:0] edge_delta;
   logic        edge_last;
   logic        edge_ready;
   logic [1:0]  edgemem_command;
   logic [31:0] edgemem_addr;
   logic [63:0] edgemem_st_data;
   logic [1:0]  edgemem_size;
   logic [3:0]  edgemem_response;
   logic [63:0] edgemem_ld_data;
   logic [3:0]  edgemem_tag;

   edge_fetch_unit dut (
      .clock           (clock),
      .reset           (reset),
      .ev_valid        (ev_valid),
      .ev_vid          (ev_vid),
      .ev_delta        (ev_delta),
      .ev_ready        (ev_ready),
      .edge_valid      (edge_valid),
      .edge_dst        (edge_dst),
      .edge_weight     (edge_weight),
      .edge_delta      (edge_delta),
      .edge_last       (edge_last),
      .edge_ready      (edge_ready),
      .edgemem_command (edgemem_command),
      .edgemem_addr    (edgemem_addr),
      .edgemem_st_data (edgemem_st_data),
      .edgemem_size    (edgemem_size),
      .edgemem_response(edgemem_response),
      .edgemem_ld_data (edgemem_ld_data),
      .edgemem_tag     (edgemem_tag)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] dst;
      logic [31:0] weight;
      logic [31:0] delta;
      logic        last;
   } exp_t;

   typedef struct {
      logic [3:0]  tag;
      logic [63:0] data;
      int          cyc;
      bit          is_row;
      int          seq;
   } pend_t;

   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   pend_t       pend[$];
   logic [31:0] load_log[$];
   logic [31:0] req_hist[$];
   logic [63:0] rowmem[64];
   bit          tag_busy[16];
   int          cyc = 0;
   int          accept_pct = 100;
   int          ready_pct = 100;
   int          ret_mode = 1;       // 0 random, 1 oldest first, 2 forced order, 3 hold edges
   int          reject_cnt = 0;
   int          edge_acc = 0;
   int          edge_acc_limit = -1;
   int          ooo_pos = 0;
   int          ooo_order[4] = '{2, 0, 3, 1};
   int          valid_seen = 0;

   function automatic logic [63:0] edge_word(input logic [31:0] idx);
      logic [31:0] k;
      logic [31:0] h;
      k = {3'b000, idx[28:0]};
      h = k * 32'h9E37_79B9;
      return {h[31:16] ^ 16'h5A5A, k[15:0], h + 32'd7};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_event(input logic [15:0] vid, input logic [31:0] delta,
                             input logic [31:0] cnt, input logic [31:0] ptr);
      int   n;
      exp_t e;
      n = 0;
      @(posedge clock); #1;
      while (!ev_ready && n < 400) begin
         @(posedge clock); #1;
         n++;
      end
      check("ev_ready_wait", ev_ready, 1);
      rowmem[vid[5:0]] = {cnt, ptr};
      for (int unsigned i = 0; i < cnt; i++) begin
         logic [63:0] w;
         w        = edge_word(ptr + i);
         e.dst    = w[63:48];
         e.weight = w[31:0];
         e.delta  = delta;
         e.last   = (i == cnt - 1);
         exp_q.push_back(e);
      end
      ev_valid = 1'b1;
      ev_vid   = vid;
      ev_delta = delta;
      @(posedge clock); #1;
      ev_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      do begin
         @(posedge clock); #1;
         n++;
      end while (!(ev_ready && exp_q.size() == 0) && n < budget);
      check(name, {31'd0, ev_ready, exp_q.size()}, {31'd0, 1'b1, 32'd0});
   endtask

   task automatic clear_logs();
      load_log.delete();
      req_hist.delete();
      edge_acc = 0;
   endtask

   // Memory model: accepts loads with a fresh tag and returns data later, possibly reordered.
   initial begin
      int pick;
      edgemem_response = '0;
      edgemem_tag      = '0;
      edgemem_ld_data  = '0;
      forever begin
         @(posedge clock); #1;
         cyc++;
         edgemem_response = '0;
         edgemem_tag      = '0;
         edgemem_ld_data  = '0;
         pick = -1;
         case (ret_mode)
            0: if (pend.size() > 0 && $urandom_range(0, 99) < 60)
                  pick = $urandom_range(0, pend.size() - 1);
            1: if (pend.size() > 0) pick = 0;
            2: for (int i = 0; i < pend.size(); i++) begin
                  if (pend[i].is_row || (ooo_pos < 4 && pend[i].seq == ooo_order[ooo_pos])) begin
                     pick = i;
                     break;
                  end
               end
            default: for (int i = 0; i < pend.size(); i++) begin
                  if (pend[i].is_row) begin
                     pick = i;
                     break;
                  end
               end
         endcase
         if (pick >= 0 && pend[pick].cyc < cyc) begin
            edgemem_tag     = pend[pick].tag;
            edgemem_ld_data = pend[pick].data;
            tag_busy[pend[pick].tag] = 1'b0;
            if (ret_mode == 2 && !pend[pick].is_row) ooo_pos++;
            pend.delete(pick);
         end
         if (!reset && edgemem_command == BUS_LOAD) begin
            bit         is_row;
            logic [3:0] tag;
            pend_t      p;
            logic [31:0] off;
            req_hist.push_back(edgemem_addr);
            is_row = (edgemem_addr < 32'h1000);
            if (reject_cnt > 0) begin
               reject_cnt--;
            end else if ($urandom_range(0, 99) < accept_pct &&
                         (is_row || edge_acc_limit < 0 || edge_acc < edge_acc_limit)) begin
               tag = '0;
               for (int t = 1; t < 16; t++) begin
                  if (!tag_busy[t] && (tag == 0 || $urandom_range(0, 1) == 1)) tag = 4'(t);
               end
               if (tag != 0) begin
                  tag_busy[tag]    = 1'b1;
                  edgemem_response = tag;
                  off              = edgemem_addr - EB;
                  p.tag    = tag;
                  p.data   = is_row ? rowmem[edgemem_addr[8:3]] : edge_word(off >> 3);
                  p.cyc    = cyc;
                  p.is_row = is_row;
                  p.seq    = is_row ? -1 : edge_acc;
                  pend.push_back(p);
                  load_log.push_back(edgemem_addr);
                  if (!is_row) edge_acc++;
               end
            end
         end
      end
   end

   initial begin
      edge_ready = 1'b0;
      forever begin
         @(posedge clock); #1;
         edge_ready = ($urandom_range(0, 99) < ready_pct);
      end
   end

   // Monitor: retire expected edges on each handshake and police hold stability.
   initial begin
      logic [81:0] snap;
      bit          held;
      exp_t        e;
      held = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            held = 1'b0;
         end else begin
            if (held) check("hold_stable",
                            {edge_valid, edge_dst, edge_weight, edge_delta, edge_last}, snap);
            held = edge_valid && !edge_ready;
            snap = {edge_valid, edge_dst, edge_weight, edge_delta, edge_last};
            if (edge_valid) valid_seen++;
            if (edge_valid && edge_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_edge: got dst %0h weight %0h expected none",
                           edge_dst, edge_weight);
               end else begin
                  e = exp_q.pop_front();
                  check("edge_dst", edge_dst, e.dst);
                  check("edge_weight", edge_weight, e.weight);
                  check("edge_delta", edge_delta, e.delta);
                  check("edge_last", edge_last, e.last);
               end
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   initial begin
      int v0;
      for (int i = 0; i < 64; i++) rowmem[i] = '0;
      for (int i = 0; i < 16; i++) tag_busy[i] = 1'b0;
      reset    = 1'b1;
      ev_valid = 1'b0;
      ev_vid   = '0;
      ev_delta = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_ev_ready", ev_ready, 1);
      check("rst_edge_valid", edge_valid, 0);
      check("rst_edge_last", edge_last, 0);
      check("rst_command", edgemem_command, BUS_NONE);
      check("rst_addr", edgemem_addr, 0);
      check("rst_st_data", edgemem_st_data, 0);
      check("rst_size", edgemem_size, DOUBLE);
      reset = 1'b0;

      // Zero-degree vertex
      clear_logs();
      v0 = valid_seen;
      send_event(16'd5, 32'hAAAA_0001, 32'd0, 32'd77);
      wait_idle("zero_idle", 100);
      check("zero_loads", load_log.size(), 1);
      check("zero_addr", load_log[0], ROW + 32'h28);
      check("zero_no_edge", valid_seen - v0, 0);

      // Three edges, in-order returns
      clear_logs();
      send_event(16'd2, 32'hDEAD_BEEF, 32'd3, 32'd10);
      wait_idle("three_idle", 200);
      check("three_loads", load_log.size(), 4);
      check("three_a0", load_log[0], ROW + 32'h10);
      check("three_a1", load_log[1], EB + 32'h50);
      check("three_a2", load_log[2], EB + 32'h58);
      check("three_a3", load_log[3], EB + 32'h60);

      // Out-of-order returns
      clear_logs();
      ooo_pos  = 0;
      ret_mode = 2;
      send_event(16'd7, 32'h0000_1234, 32'd4, 32'd100);
      wait_idle("ooo_idle", 200);
      ret_mode = 1;

      // Backpressure with a full buffer
      clear_logs();
      ready_pct = 0;
      send_event(16'd9, 32'h5555_0009, 32'd10, 32'd200);
      repeat (40) @(posedge clock);
      #1;
      check("bp_loads_capped", load_log.size(), 5);
      check("bp_cmd_none", edgemem_command, BUS_NONE);
      check("bp_valid_held", edge_valid, 1);
      ready_pct = 100;
      wait_idle("bp_idle", 300);
      check("bp_loads_total", load_log.size(), 11);
      check("bp_last_addr", load_log[10], EB + 32'd209 * 32'd8);

      // Memory rejects the pointer load three times
      clear_logs();
      reject_cnt = 3;
      send_event(16'd12, 32'h0C0C_0C0C, 32'd1, 32'd300);
      wait_idle("rej_idle", 200);
      check("rej_hist_len", req_hist.size() >= 5, 1);
      for (int i = 0; i < 4; i++) check("rej_hold_addr", req_hist[i], ROW + 32'h60);
      check("rej_next_addr", req_hist[4], EB + 32'd300 * 32'd8);
      check("rej_loads", load_log.size(), 2);

      // Reset while two edge tags are in flight
      clear_logs();
      ret_mode       = 3;
      edge_acc_limit = 2;
      send_event(16'd20, 32'h2020_2020, 32'd6, 32'd400);
      v0 = 0;
      while (edge_acc < 2 && v0 < 100) begin
         @(posedge clock); #1;
         v0++;
      end
      check("mid_two_inflight", edge_acc, 2);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      exp_q.delete();
      edge_acc_limit = -1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("mid_rst_ev_ready", ev_ready, 1);
      check("mid_rst_cmd", edgemem_command, BUS_NONE);
      check("mid_rst_addr", edgemem_addr, 0);
      v0       = valid_seen;
      ret_mode = 1;
      repeat (12) @(posedge clock);
      #1;
      check("mid_late_no_edge", valid_seen - v0, 0);
      check("mid_still_idle", ev_ready, 1);

      // Randomized traffic
      accept_pct = 70;
      ready_pct  = 70;
      ret_mode   = 0;
      for (int n = 0; n < 30; n++) begin
         logic [31:0] ptr;
         ptr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                           : 32'($urandom_range(0, 2000));
         send_event(16'($urandom_range(0, 63)), $urandom, 32'($urandom_range(0, 12)), ptr);
      end
      wait_idle("rand_idle", 3000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
